pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 98 +++++++++
 tb/tb_pipelined_adder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Ripple-carry adder/subtractor split into STAGES chunk-wide pipeline stages.
// Stage k adds chunk k and forwards the carry; the pipe stalls as a whole on backpressure.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   logic             advance;
   // word_q mixes completed sum chunks (low) with untouched A chunks (high).
   // b_q keeps only the not-yet-consumed B chunks, shifted down to bit 0.
   logic [WIDTH-1:0] word_q  [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic             carry_q [STAGES];
   logic             valid_q [STAGES];
   logic             ovf_q;

   assign out_valid = valid_q[STAGES-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] word_in;
         logic [WIDTH-1:0] b_in;
         logic [WIDTH-1:0] word_next;
         logic             carry_in;
         logic             valid_in;
         logic [CW:0]      chunk_sum;

         if (gi == 0) begin : g_entry
            assign word_in  = a;
            assign b_in     = sub ? ~b : b;
            assign carry_in = sub | cin;
            assign valid_in = in_valid;
         end else begin : g_link
            assign word_in  = word_q[gi-1];
            assign b_in     = b_q[gi-1];
            assign carry_in = carry_q[gi-1];
            assign valid_in = valid_q[gi-1];
         end

         assign chunk_sum = {1'b0, word_in[gi*CW +: CW]} + {1'b0, b_in[CW-1:0]}
                          + {{CW{1'b0}}, carry_in};

         always_comb begin
            word_next = word_in;
            word_next[gi*CW +: CW] = chunk_sum[CW-1:0];
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               valid_q[gi] <= 1'b0;
               word_q[gi]  <= '0;
               carry_q[gi] <= 1'b0;
            end else if (advance) begin
               valid_q[gi] <= valid_in;
               word_q[gi]  <= word_next;
               b_q[gi]     <= b_in >> CW;
               carry_q[gi] <= chunk_sum[CW];
            end
         end

         // Top chunk still holds A's sign; B's sign sits at bit CW-1 after shifting.
         if (gi == STAGES - 1) begin : g_last
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  ovf_q <= 1'b0;
               end else if (advance) begin
                  ovf_q <= (word_in[WIDTH-1] == b_in[CW-1]) &&
                           (chunk_sum[CW-1] != word_in[WIDTH-1]);
               end
            end
         end
      end
   endgenerate

   assign sum  = word_q[STAGES-1];
   assign cout = carry_q[STAGES-1];
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors, stall, reset and random traffic on
// three configurations (16/4, 32/4, 8/1) checked against a queued reference model.
module tb_pipelined_adder;

   logic        clk;
   logic        rst_n;
   logic        iv      [3];
   logic        ordy    [3];
   logic [31:0] a_in    [3];
   logic [31:0] b_in    [3];
   logic        cin_in  [3];
   logic        sub_in  [3];

   logic        ir0, ir1, ir2, ov0, ov1, ov2;
   logic        cout0, cout1, cout2, ovf0, ovf1, ovf2;
   logic [15:0] sum0;
   logic [31:0] sum1;
   logic [7:0]  sum2;

   logic [33:0] q0 [$];
   logic [33:0] q1 [$];
   logic [33:0] q2 [$];

   int checks = 0;
   int errors = 0;

   pipelined_adder #(.WIDTH(16), .STAGES(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
      .a(a_in[0][15:0]), .b(b_in[0][15:0]), .cin(cin_in[0]), .sub(sub_in[0]),
      .out_valid(ov0), .out_ready(ordy[0]), .sum(sum0), .cout(cout0), .ovf(ovf0));

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
      .a(a_in[1]), .b(b_in[1]), .cin(cin_in[1]), .sub(sub_in[1]),
      .out_valid(ov1), .out_ready(ordy[1]), .sum(sum1), .cout(cout1), .ovf(ovf1));

   pipelined_adder #(.WIDTH(8), .STAGES(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
      .a(a_in[2][7:0]), .b(b_in[2][7:0]), .cin(cin_in[2]), .sub(sub_in[2]),
      .out_valid(ov2), .out_ready(ordy[2]), .sum(sum2), .cout(cout2), .ovf(ovf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wd(input int d);
      return (d == 0) ? 16 : (d == 1) ? 32 : 8;
   endfunction

   // Reference: plain wide arithmetic, result packed as {ovf, cout, sum}.
   function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic s);
      logic [63:0] mask, xe, ye, full;
      logic [31:0] r;
      logic        co, ov;
      mask = (64'd1 << w) - 64'd1;
      xe   = {32'b0, x} & mask;
      ye   = s ? (~{32'b0, y}) & mask : {32'b0, y} & mask;
      full = xe + ye + (s ? 64'd1 : {63'b0, c});
      r    = full[31:0] & mask[31:0];
      co   = full[w];
      ov   = (xe[w-1] == ye[w-1]) && (r[w-1] != xe[w-1]);
      return {ov, co, r};
   endfunction

   task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Sample every DUT at the falling edge: pop/compare on output transfer, push on acceptance.
   task automatic observe();
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         logic        ovd, ird, have;
         logic [33:0] got, e;
         case (d)
            0:       begin ovd = ov0; ird = ir0; got = {ovf0, cout0, 16'b0, sum0}; end
            1:       begin ovd = ov1; ird = ir1; got = {ovf1, cout1, sum1}; end
            default: begin ovd = ov2; ird = ir2; got = {ovf2, cout2, 24'b0, sum2}; end
         endcase
         if (ovd && ordy[d]) begin
            have = 1'b0;
            e    = '0;
            case (d)
               0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            checks++;
            assert (have && got === e) else begin
               errors++;
               $error("FAIL dut%0d_result observed=%h expected=%h queued=%0b", d, got, e, have);
            end
         end
         if (rst_n && iv[d] && ird) begin
            e = model(wd(d), a_in[d], b_in[d], cin_in[d], sub_in[d]);
            case (d)
               0:       q0.push_back(e);
               1:       q1.push_back(e);
               default: q2.push_back(e);
            endcase
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      observe();
      tick();
   endtask

   // One isolated beat into dut0 with exact latency and constant result checks.
   task automatic send0(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
      a_in[0] = {16'b0, x}; b_in[0] = {16'b0, y}; cin_in[0] = c; sub_in[0] = s; iv[0] = 1'b1;
      $display("send a=%h b=%h cin=%0b sub=%0b", x, y, c, s);
      cycle();
      iv[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         observe();
         chk("lat_early", {33'b0, ov0}, 34'd0);
         tick();
      end
      observe();
      chk("lat_hit", {33'b0, ov0}, 34'd1);
      chk("vec_result", {ovf0, cout0, 16'b0, sum0}, {eo, ec, 16'b0, es});
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b1; a_in[d] = '0; b_in[d] = '0; cin_in[d] = 1'b0; sub_in[d] = 1'b0;
      end

      // Reset state, and a beat offered during reset must not be captured.
      tick(); tick();
      iv[0] = 1'b1; a_in[0] = 32'h0000_1111; b_in[0] = 32'h0000_2222;
      observe();
      chk("rst_out_valid", {33'b0, ov0}, 34'd0);
      chk("rst_outputs", {ovf0, cout0, 16'b0, sum0}, 34'd0);
      chk("rst_in_ready", {33'b0, ir0}, 34'd1);
      tick();
      iv[0] = 1'b0;
      rst_n = 1'b1;

      // Directed vectors.
      send0(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      send0(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
      send0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send0(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send0(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      send0(16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Eight back-to-back mixed beats, then five stalled cycles.
      for (int i = 0; i < 8; i++) begin
         a_in[0] = {16'b0, 16'(16'h1000 * i + 16'h0123)};
         b_in[0] = {16'b0, 16'(16'hF00F - 16'h0777 * i)};
         cin_in[0] = i[0]; sub_in[0] = i[1]; iv[0] = 1'b1;
         $display("burst beat %0d a=%h b=%h sub=%0b", i, a_in[0][15:0], b_in[0][15:0], sub_in[0]);
         cycle();
      end
      a_in[0] = 32'h0000_ABCD; b_in[0] = 32'h0000_1357;
      ordy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         observe();
         chk("stall_in_ready", {33'b0, ir0}, 34'd0);
         chk("stall_out_valid", {33'b0, ov0}, 34'd1);
         if (q0.size() > 0) chk("stall_hold", {ovf0, cout0, 16'b0, sum0}, q0[0]);
         tick();
      end
      iv[0] = 1'b0; ordy[0] = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      chk("burst_drained", 34'(q0.size()), 34'd0);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         a_in[0] = {16'b0, 16'(16'h0F0F + i)}; b_in[0] = 32'h0000_0101; iv[0] = 1'b1;
         cycle();
      end
      iv[0] = 1'b0; rst_n = 1'b0;
      cycle();
      q0.delete();
      observe();
      chk("midrst_out_valid", {33'b0, ov0}, 34'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         observe();
         chk("no_stale", {33'b0, ov0}, 34'd0);
         tick();
      end
      send0(16'h2468, 16'h1357, 1'b1, 1'b0, 16'h37C0, 1'b0, 1'b0);

      // Random traffic on all three configurations.
      for (int n = 0; n < 16000; n++) begin
         for (int d = 0; d < 3; d++) begin
            iv[d]     = ($urandom_range(0, 3) != 0);
            ordy[d]   = ($urandom_range(0, 3) != 0);
            a_in[d]   = $urandom;
            b_in[d]   = $urandom;
            cin_in[d] = $urandom_range(0, 1) == 1;
            sub_in[d] = $urandom_range(0, 1) == 1;
            if (d != 1) begin
               a_in[d] = a_in[d] & ((32'd1 << wd(d)) - 32'd1);
               b_in[d] = b_in[d] & ((32'd1 << wd(d)) - 32'd1);
            end
         end
         cycle();
      end
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b1;
      end
      for (int i = 0; i < 12; i++) cycle();
      chk("rand_drain_16x4", 34'(q0.size()), 34'd0);
      chk("rand_drain_32x4", 34'(q1.size()), 34'd0);
      chk("rand_drain_8x1", 34'(q2.size()), 34'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
